// File: rtl/modulo_counter_chain_pkg.sv
// Shared definitions for the modulo counter chain.
//   DIR_UP / DIR_DOWN : encoding of the dir input
//   MOD_FIELD_W       : width of one modulus field in the packed MODULI parameter
//   MAX_STAGES        : largest chain the modulus helper can address
//   mod_of()          : extract the modulus of stage i from a packed MODULI vector
package modulo_counter_chain_pkg;

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam int   MOD_FIELD_W = 32;
  localparam int   MAX_STAGES  = 16;

  // Callers zero-extend their MODULI vector to the full MAX_STAGES width.
  function automatic int unsigned mod_of(
    input logic [MOD_FIELD_W*MAX_STAGES-1:0] moduli,
    input int                                i
  );
    return moduli[MOD_FIELD_W*i +: MOD_FIELD_W];
  endfunction

endpackage

// File: rtl/modulo_counter_chain_stage.sv
// One digit of the modulo counter chain.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear, load   : synchronous clear / parallel load (clear wins)
//   load_val      : load value, clamped to MOD-1 when out of range
//   en            : advance this digit this cycle
//   dir           : 0 = up, 1 = down
//   hold_at_term  : whole chain is saturating; keep the terminal value
//   count         : current digit value
//   at_term       : digit sits at its terminal value for the current dir
//   carry         : registered pulse, digit wrapped on the last edge
module mod_counter_stage
  import modulo_counter_chain_pkg::*;
#(
  parameter int unsigned MOD = 60,
  parameter int          W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  input  logic         hold_at_term,
  output logic [W-1:0] count,
  output logic         at_term,
  output logic         carry
);

  localparam logic [W-1:0] TERM_UP = W'(MOD - 1);

  logic [W-1:0] load_clamped;

  assign at_term = (dir == DIR_DOWN) ? (count == '0) : (count == TERM_UP);

  always_comb begin
    load_clamped = load_val;
    if (32'(load_val) >= MOD) load_clamped = TERM_UP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (en) begin
        if (at_term) begin
          // A saturating chain keeps every digit parked at its limit.
          if (!hold_at_term) begin
            count <= (dir == DIR_UP) ? '0 : TERM_UP;
            carry <= 1'b1;
          end
        end else begin
          count <= (dir == DIR_UP) ? count + W'(1) : count - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/modulo_counter_chain.sv
// Cascade of mixed-radix modulo counters (default 60/60/24, i.e. h:m:s).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous clear of all stages
//   load         : synchronous parallel load from load_value (stage i in [W*i +: W])
//   tick         : advance the chain by one count
//   dir          : 0 = up, 1 = down
//   count        : stage i value in [W*i +: W]
//   stage_carry  : per-stage registered wrap pulse
//   carry_out    : registered pulse, whole chain wrapped (WRAP=1)
//   saturated    : registered level, chain held at its limit (WRAP=0)
module modulo_counter_chain
  import modulo_counter_chain_pkg::*;
#(
  parameter int                              STAGES = 3,
  parameter int                              W      = 6,
  parameter logic [MOD_FIELD_W*STAGES-1:0]   MODULI = {32'd24, 32'd60, 32'd60},
  parameter bit                              WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [STAGES*W-1:0]   load_value,
  input  logic                  tick,
  input  logic                  dir,
  output logic [STAGES*W-1:0]   count,
  output logic [STAGES-1:0]     stage_carry,
  output logic                  carry_out,
  output logic                  saturated
);

  localparam logic [MOD_FIELD_W*MAX_STAGES-1:0] MODULI_EXT =
    (MOD_FIELD_W*MAX_STAGES)'(MODULI);

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] at_term;
  logic              chain_term;
  logic              hold_at_term;

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("modulo_counter_chain: STAGES=%0d out of range", STAGES);
  end

  // Combinational enable chain: every stage advances on the same edge.
  assign en[0] = tick;
  for (genvar i = 1; i < STAGES; i++) begin : g_en
    assign en[i] = en[i-1] & at_term[i-1];
  end

  assign chain_term   = tick & (&at_term);
  assign hold_at_term = !WRAP & chain_term;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int unsigned MOD_I = mod_of(MODULI_EXT, i);

    if (MOD_I < 2 || longint'(MOD_I) > (longint'(1) << W)) begin : g_bad_mod
      $error("modulo_counter_chain: stage %0d modulus %0d out of range", i, MOD_I);
    end

    mod_counter_stage #(
      .MOD (MOD_I),
      .W   (W)
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .load         (load),
      .load_val     (load_value[W*i +: W]),
      .en           (en[i]),
      .dir          (dir),
      .hold_at_term (hold_at_term),
      .count        (count[W*i +: W]),
      .at_term      (at_term[i]),
      .carry        (stage_carry[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_out <= 1'b0;
      saturated <= 1'b0;
    end else if (clear || load) begin
      carry_out <= 1'b0;
      saturated <= 1'b0;
    end else begin
      carry_out <= WRAP & chain_term;
      // Any tick that moves the chain leaves the limit, so saturated simply
      // follows whether this tick was held.
      if (tick) saturated <= hold_at_term;
    end
  end

endmodule

// File: tb/tb_modulo_counter_chain.sv
// Bench for modulo_counter_chain: a wrapping and a saturating instance share
// the same stimulus; a total-seconds reference model feeds a scoreboard.
module tb_modulo_counter_chain;

  localparam int DAY = 86400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [17:0] load_value = '0;
  logic        tick = 1'b0;
  logic        dir = 1'b0;

  logic [17:0] count_w, count_s;
  logic [2:0]  sc_w, sc_s;
  logic        co_w, co_s, sat_w, sat_s;

  always #5 clk = ~clk;

  modulo_counter_chain #(.WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
    .tick(tick), .dir(dir), .count(count_w), .stage_carry(sc_w),
    .carry_out(co_w), .saturated(sat_w)
  );

  modulo_counter_chain #(.WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value),
    .tick(tick), .dir(dir), .count(count_s), .stage_carry(sc_s),
    .carry_out(co_s), .saturated(sat_s)
  );

  typedef struct {
    logic [17:0] cw;
    logic [2:0]  scw;
    logic        cow;
    logic [17:0] cs;
    logic [2:0]  scs;
    logic        sats;
  } exp_t;

  exp_t sbq[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          vw = 0, vs = 0;
  logic        satm = 1'b0;
  logic [2:0]  scw_m = '0, scs_m = '0;
  logic        cow_m = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [17:0] pack(input int v);
    logic [5:0] h, m, s;
    h = 6'(v / 3600);
    m = 6'((v / 60) % 60);
    s = 6'(v % 60);
    return {h, m, s};
  endfunction

  function automatic int clamp_val(input logic [17:0] lv);
    int h, m, s;
    h = int'(lv[17:12]); if (h > 23) h = 23;
    m = int'(lv[11:6]);  if (m > 59) m = 59;
    s = int'(lv[5:0]);   if (s > 59) s = 59;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic step_v(input int v, input logic d, output int nv, output logic [2:0] sc);
    if (d == 1'b0) begin
      nv = (v == DAY - 1) ? 0 : v + 1;
      sc = {v == DAY - 1, (v % 3600) == 3599, (v % 60) == 59};
    end else begin
      nv = (v == 0) ? DAY - 1 : v - 1;
      sc = {v == 0, (v % 3600) == 0, (v % 60) == 0};
    end
  endtask

  task automatic model_reset();
    vw = 0; vs = 0; satm = 1'b0; scw_m = '0; scs_m = '0; cow_m = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.cw = pack(vw); e.scw = scw_m; e.cow = cow_m;
    e.cs = pack(vs); e.scs = scs_m; e.sats = satm;
    sbq.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check_val({tag, ".count_w"}, 32'(count_w), 32'(e.cw));
    check_val({tag, ".carry_w"}, 32'(sc_w),    32'(e.scw));
    check_val({tag, ".cout_w"},  32'(co_w),    32'(e.cow));
    check_val({tag, ".sat_w"},   32'(sat_w),   32'd0);
    check_val({tag, ".count_s"}, 32'(count_s), 32'(e.cs));
    check_val({tag, ".carry_s"}, 32'(sc_s),    32'(e.scs));
    check_val({tag, ".cout_s"},  32'(co_s),    32'd0);
    check_val({tag, ".sat_s"},   32'(sat_s),   32'(e.sats));
  endtask

  task automatic model_edge(input logic c, input logic l, input logic [17:0] lv,
                            input logic t, input logic d);
    int nv;
    logic [2:0] sc;
    scw_m = '0; scs_m = '0; cow_m = 1'b0;
    if (c) begin
      vw = 0; vs = 0; satm = 1'b0;
    end else if (l) begin
      vw = clamp_val(lv); vs = vw; satm = 1'b0;
    end else if (t) begin
      step_v(vw, d, nv, sc);
      vw = nv; scw_m = sc; cow_m = sc[2];
      if ((d == 1'b0 && vs == DAY - 1) || (d == 1'b1 && vs == 0)) begin
        satm = 1'b1;
      end else begin
        step_v(vs, d, nv, sc);
        vs = nv; scs_m = sc; satm = 1'b0;
      end
    end
  endtask

  task automatic drive(input string tag, input logic c, input logic l,
                       input logic [17:0] lv, input logic t, input logic d);
    @(negedge clk);
    clear = c; load = l; load_value = lv; tick = t; dir = d;
    model_edge(c, l, lv, t, d);
    push_exp();
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  initial begin
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    push_exp();
    #1 check_pop("reset_state");

    // Up cascade from 00:00:59
    drive("load_59",   1'b0, 1'b1, hms(0, 0, 59), 1'b0, 1'b0);
    drive("up_casc",   1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive("casc_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Asynchronous reset while a carry pulse is showing
    drive("load_59b",  1'b0, 1'b1, hms(0, 0, 59), 1'b0, 1'b0);
    drive("pulse_on",  1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    model_reset();
    push_exp();
    #1 check_pop("async_rst");
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; load = 1'b0; clear = 1'b0;

    // Full wrap up
    drive("load_max",  1'b0, 1'b1, hms(23, 59, 59), 1'b0, 1'b0);
    drive("full_wrap", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive("wrap_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Down wrap from zero
    drive("clear",     1'b1, 1'b0, '0, 1'b0, 1'b0);
    drive("down_wrap", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    drive("down_next", 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Saturation at the top, then leave it downward
    drive("load_max2", 1'b0, 1'b1, hms(23, 59, 59), 1'b0, 1'b0);
    drive("sat_up1",   1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive("sat_up2",   1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive("sat_up3",   1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive("sat_idle",  1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive("sat_down",  1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Priority and clamping
    drive("load_clamp", 1'b0, 1'b1, hms(10, 63, 63), 1'b1, 1'b0);
    drive("clr_ld",     1'b1, 1'b1, hms(5, 6, 7),    1'b1, 1'b0);

    // Reset held across an edge that would have wrapped the chain
    drive("load_max3", 1'b0, 1'b1, hms(23, 59, 59), 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b0; tick = 1'b1; dir = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    push_exp();
    @(posedge clk);
    #1 check_pop("rst_tick");
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;

    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [17:0] lv;
      r  = int'($urandom_range(0, 99));
      lv = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
      if (r < 4)
        drive("rnd_clear", 1'b1, 1'b0, lv, 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 14)
        drive("rnd_load", 1'b0, 1'b1, lv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r < 24)
        drive("rnd_load_edge", 1'b0, 1'b1,
              (r < 19) ? hms(23, 59, 59) : hms(0, 0, 0), 1'b0, 1'b0);
      else
        drive("rnd_tick", 1'b0, 1'b0, lv, 1'(r < 90), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
